// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX state encodings, parity codes, baud-rate derivation.
// Latency: none (declarations only).
// Backpressure: none; consumers handle their own handshakes.
package uart_pkg;

   localparam int DEFAULT_BASE_FREQ = 50_000_000;
   localparam int DEFAULT_BAUD_RATE = 115_200;

   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_ODD  = 2'd1;
   localparam logic [1:0] PARITY_EVEN = 2'd2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Clock cycles per line bit; integer division truncates toward zero.
   function automatic int counts_per_bit(input int base_freq, input int baud_rate);
      return base_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..COUNTS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: bit_end is high during the final cycle of every bit period; clear takes effect next edge.
// Backpressure: none; free-running whenever clear is low.
module uart_baud_counter import uart_pkg::*; #(
   parameter int COUNTS_PER_BIT = counts_per_bit(DEFAULT_BASE_FREQ, DEFAULT_BAUD_RATE)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int            CW   = (COUNTS_PER_BIT > 1) ? $clog2(COUNTS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(COUNTS_PER_BIT - 1);

   logic [CW-1:0] count;

   // Count up through the bit period, wrapping on the last cycle or when held clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, stop bit(s); line idles high.
// Latency: line goes low one cycle after an accepted tx_start; tx_done pulses the cycle after the last stop cycle.
// Backpressure: tx_start is ignored while busy (no queuing). UART_TX_TWO_STOP_BITS_EN selects two stop bits.
module uart_transmitter import uart_pkg::*; #(
   parameter int BASE_FREQ = DEFAULT_BASE_FREQ,
   parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic [1:0] parity_type,
   output logic       serial_data_out,
   output logic       busy,
   output logic       tx_done
);

   localparam int COUNTS_PER_BIT = counts_per_bit(BASE_FREQ, BAUD_RATE);

   tx_state_t  state, state_nxt;
   logic [2:0] idx, idx_nxt;
   logic [7:0] data, data_nxt;
   logic [1:0] ptype, ptype_nxt;
   logic       par_bit, par_bit_nxt;
   logic       line_nxt, busy_nxt, done_nxt;
   logic       bit_end;
`ifdef UART_TX_TWO_STOP_BITS_EN
   logic       stop2, stop2_nxt;
`endif

   // Timer is held at zero while idle so the start bit gets a full period.
   uart_baud_counter #(.COUNTS_PER_BIT(COUNTS_PER_BIT)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == TX_IDLE),
      .bit_end (bit_end)
   );

   // Next-state and next-output decode; the line value is computed one cycle ahead so it leaves a flop.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      data_nxt    = data;
      ptype_nxt   = ptype;
      par_bit_nxt = par_bit;
      line_nxt    = serial_data_out;
      done_nxt    = 1'b0;
`ifdef UART_TX_TWO_STOP_BITS_EN
      stop2_nxt   = stop2;
`endif
      case (state)
         TX_IDLE: begin
            line_nxt = 1'b1;
            if (tx_start) begin
               state_nxt   = TX_START;
               line_nxt    = 1'b0;
               data_nxt    = tx_data;
               idx_nxt     = 3'd0;
               // Code 3 is not a real mode; store it as no parity.
               ptype_nxt   = (parity_type == 2'd3) ? PARITY_NONE : parity_type;
               par_bit_nxt = (parity_type == PARITY_ODD) ? ~^tx_data : ^tx_data;
            end
         end
         TX_START: begin
            if (bit_end) begin
               state_nxt = TX_DATA;
               line_nxt  = data[0];
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               if (idx == 3'd7) begin
                  idx_nxt = 3'd0;
                  if (ptype != PARITY_NONE) begin
                     state_nxt = TX_PARITY;
                     line_nxt  = par_bit;
                  end else begin
                     state_nxt = TX_STOP;
                     line_nxt  = 1'b1;
                  end
               end else begin
                  idx_nxt  = idx + 3'd1;
                  line_nxt = data[idx_nxt];
               end
            end
         end
         TX_PARITY: begin
            if (bit_end) begin
               state_nxt = TX_STOP;
               line_nxt  = 1'b1;
            end
         end
         TX_STOP: begin
            line_nxt = 1'b1;
            if (bit_end) begin
`ifdef UART_TX_TWO_STOP_BITS_EN
               if (stop2) begin
                  state_nxt = TX_IDLE;
                  done_nxt  = 1'b1;
                  stop2_nxt = 1'b0;
               end else begin
                  stop2_nxt = 1'b1;
               end
`else
               state_nxt = TX_IDLE;
               done_nxt  = 1'b1;
`endif
            end
         end
         default: begin
            state_nxt = TX_IDLE;
            line_nxt  = 1'b1;
         end
      endcase
      busy_nxt = (state_nxt != TX_IDLE);
   end

   // State and registered outputs; reset aborts any frame and forces the line high at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= TX_IDLE;
         idx             <= 3'd0;
         data            <= 8'd0;
         ptype           <= PARITY_NONE;
         par_bit         <= 1'b0;
         serial_data_out <= 1'b1;
         busy            <= 1'b0;
         tx_done         <= 1'b0;
`ifdef UART_TX_TWO_STOP_BITS_EN
         stop2           <= 1'b0;
`endif
      end else begin
         state           <= state_nxt;
         idx             <= idx_nxt;
         data            <= data_nxt;
         ptype           <= ptype_nxt;
         par_bit         <= par_bit_nxt;
         serial_data_out <= line_nxt;
         busy            <= busy_nxt;
         tx_done         <= done_nxt;
`ifdef UART_TX_TWO_STOP_BITS_EN
         stop2           <= stop2_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: table of known frames, hand-written corner sequences, random frames.
// Expected line waveform is rebuilt from the frame format; a mid-bit sampling receiver decodes the line.
module tb_uart_transmitter;

   localparam int CPB = 50_000_000 / 115_200;
`ifdef UART_TX_TWO_STOP_BITS_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif
   localparam int EXTRA = (STOP_BITS - 1) * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [1:0] parity_type;
   logic       serial_data_out;
   logic       busy;
   logic       tx_done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_transmitter dut (
      .clk             (clk),
      .rst             (rst),
      .tx_start        (tx_start),
      .tx_data         (tx_data),
      .parity_type     (parity_type),
      .serial_data_out (serial_data_out),
      .busy            (busy),
      .tx_done         (tx_done)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] ptype;
      int         exp_len;
      bit         has_par;
      logic       par_bit;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Frame as a list of line levels, one per bit time.
   task automatic build_frame(input logic [7:0] d, input logic [1:0] p,
                              output logic [11:0] fb, output int nb);
      int ones;
      fb = '1;
      nb = 0;
      fb[nb] = 1'b0; nb++;
      for (int i = 0; i < 8; i++) begin
         fb[nb] = d[i]; nb++;
      end
      if (p == 2'd1 || p == 2'd2) begin
         ones = $countones(d);
         fb[nb] = (p == 2'd1) ? (ones % 2 == 0) : (ones % 2 == 1);
         nb++;
      end
      for (int s = 0; s < STOP_BITS; s++) begin
         fb[nb] = 1'b1; nb++;
      end
   endtask

   task automatic strobe(input logic [7:0] d, input logic [1:0] p);
      tx_data     = d;
      parity_type = p;
      tx_start    = 1'b1;
   endtask

   task automatic idle_check(input int ncyc, input string name);
      int bad = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (serial_data_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
      end
      check(name, bad, 0);
   endtask

   // Called at the negedge where tx_start was just raised; returns at the negedge showing tx_done.
   task automatic expect_frame(input logic [7:0] d, input logic [1:0] p, input int glitch_k,
                               input bit hold, input string tag, output int len,
                               output logic [7:0] rxb, output logic rxpar, output int rx_bad);
      logic [11:0] fb;
      logic [11:0] smp = '1;
      int nb, n, ns = 0;
      int bad_line = 0, bad_busy = 0;
      bit hp;
      build_frame(d, p, fb, nb);
      n   = nb * CPB;
      len = -1;
      for (int k = 0; k <= n + CPB; k++) begin
         @(negedge clk);
         if (k == 0 && !hold) tx_start = 1'b0;
         if (tx_done === 1'b1) begin
            len = k;
            break;
         end
         if (k >= n || serial_data_out !== fb[k / CPB]) bad_line++;
         if (busy !== 1'b1) bad_busy++;
         if ((k % CPB) == (CPB / 2) && ns < 12) begin
            smp[ns] = serial_data_out;
            ns++;
         end
         if (k == glitch_k) begin
            tx_start    = 1'b1;
            tx_data     = 8'hFF;
            parity_type = 2'd1;
         end else if (k == glitch_k + 1 && !hold) begin
            tx_start = 1'b0;
         end
      end
      check({tag, "_line_bits"}, bad_line, 0);
      check({tag, "_busy_in_frame"}, bad_busy, 0);
      check({tag, "_frame_len"}, len, n);
      check({tag, "_done_busy_low"}, busy, 0);
      check({tag, "_done_line_high"}, serial_data_out, 1);
      // Receiver view: mid-bit samples, framing and parity validation.
      hp = (p == 2'd1 || p == 2'd2);
      for (int i = 0; i < 8; i++) rxb[i] = smp[1 + i];
      rxpar  = hp ? smp[9] : 1'b0;
      rx_bad = 0;
      if (ns != nb) rx_bad++;
      if (smp[0] !== 1'b0) rx_bad++;
      if (smp[hp ? 10 : 9] !== 1'b1) rx_bad++;
      if (hp && ((($countones({rxb, rxpar}) % 2) == 1) != (p == 2'd1))) rx_bad++;
      check({tag, "_rx_byte"}, rxb, d);
      check({tag, "_rx_errors"}, rx_bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vecs[5];
      int         len, rx_bad, gk;
      logic [7:0] rxb, d;
      logic [1:0] p;
      logic       rxpar;

      vecs[0] = '{8'hA5, 2'd0, 4340 + EXTRA, 1'b0, 1'b0};
      vecs[1] = '{8'h07, 2'd1, 4774 + EXTRA, 1'b1, 1'b0};
      vecs[2] = '{8'h07, 2'd2, 4774 + EXTRA, 1'b1, 1'b1};
      vecs[3] = '{8'h3C, 2'd2, 4774 + EXTRA, 1'b1, 1'b0};
      vecs[4] = '{8'h3C, 2'd3, 4340 + EXTRA, 1'b0, 1'b0};

      rst         = 1'b1;
      tx_start    = 1'b0;
      tx_data     = 8'h00;
      parity_type = 2'd0;
      repeat (3) @(negedge clk);
      check("reset_line", serial_data_out, 1);
      check("reset_busy", busy, 0);
      check("reset_done", tx_done, 0);
      rst = 1'b0;
      idle_check(200, "idle_no_strobe");

      // Known frames from the table.
      for (int i = 0; i < 5; i++) begin
         strobe(vecs[i].data, vecs[i].ptype);
         expect_frame(vecs[i].data, vecs[i].ptype, -1, 1'b0, $sformatf("tbl%0d", i),
                      len, rxb, rxpar, rx_bad);
         check($sformatf("tbl%0d_len", i), len, vecs[i].exp_len);
         if (vecs[i].has_par) check($sformatf("tbl%0d_parity_bit", i), rxpar, vecs[i].par_bit);
         idle_check(20, $sformatf("tbl%0d_idle_after", i));
      end

      // Second strobe (with different data/parity) mid-frame is ignored.
      strobe(8'h55, 2'd0);
      expect_frame(8'h55, 2'd0, 1500, 1'b0, "ignore_mid", len, rxb, rxpar, rx_bad);
      idle_check(20, "ignore_mid_idle");

      // Strobe in the tx_done cycle: next frame follows with no idle gap.
      strobe(8'h3C, 2'd1);
      expect_frame(8'h3C, 2'd1, -1, 1'b0, "chain_a", len, rxb, rxpar, rx_bad);
      strobe(8'hC3, 2'd2);
      expect_frame(8'hC3, 2'd2, -1, 1'b0, "chain_b", len, rxb, rxpar, rx_bad);
      idle_check(20, "chain_idle");

      // tx_start held high: frames repeat back-to-back.
      strobe(8'h81, 2'd0);
      expect_frame(8'h81, 2'd0, -1, 1'b1, "hold_a", len, rxb, rxpar, rx_bad);
      expect_frame(8'h81, 2'd0, -1, 1'b1, "hold_b", len, rxb, rxpar, rx_bad);
      tx_start = 1'b0;
      idle_check(50, "hold_idle");

      // Random frames, some with a spurious mid-frame strobe.
      for (int r = 0; r < 3; r++) begin
         d  = 8'($urandom);
         p  = 2'($urandom_range(0, 3));
         gk = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 4000));
         strobe(d, p);
         expect_frame(d, p, gk, 1'b0, $sformatf("rnd%0d", r), len, rxb, rxpar, rx_bad);
         idle_check(10, $sformatf("rnd%0d_idle", r));
      end

      // Reset during data bit 4 aborts the frame.
      strobe(8'hA5, 2'd0);
      @(negedge clk);
      tx_start = 1'b0;
      repeat (5 * CPB + CPB / 2) @(negedge clk);
      check("abort_busy_before", busy, 1);
      check("abort_line_bit4", serial_data_out, 0);
      rst = 1'b1;
      #1;
      check("abort_line_high", serial_data_out, 1);
      check("abort_busy_low", busy, 0);
      check("abort_done_low", tx_done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_check(600, "abort_no_resume");

      // Transmitter works normally after the abort.
      d = 8'($urandom);
      p = 2'($urandom_range(0, 3));
      strobe(d, p);
      expect_frame(d, p, -1, 1'b0, "post_abort", len, rxb, rxpar, rx_bad);
      idle_check(10, "post_abort_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
